// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode hex display driver: one digit per prescaler slot,
// blank gap at each slot start, optional leading-zero blanking, frame-synchronous data update.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    input  logic                      lzb,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                seg,
    output logic                      frame,
    output logic                      pending
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_reg;
    logic [IW-1:0]           idx_reg;
    logic                    slot_end;
    logic                    blank_gap;

    logic [4*NUM_DIGITS-1:0] pend_data_reg;
    logic [NUM_DIGITS-1:0]   pend_dp_reg;
    logic [NUM_DIGITS-1:0]   pend_en_reg;
    logic                    pending_reg;

    logic [4*NUM_DIGITS-1:0] act_data_reg;
    logic [NUM_DIGITS-1:0]   act_dp_reg;
    logic [NUM_DIGITS-1:0]   act_en_reg;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [7:0]              digit_seg [NUM_DIGITS];
    logic [7:0]              seg_sel;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic [7:0]              seg_reg;

    // Active-low g..a patterns for a hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end = (presc_reg == PRESC_LAST);
    assign frame    = slot_end && (idx_reg == IDX_LAST);
    assign pending  = pending_reg;
    assign an       = an_reg;
    assign seg      = seg_reg;

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign blank_gap = (presc_reg < PW'(BLANK_CYCLES));
        end else begin : g_no_blank
            assign blank_gap = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            idx_reg   <= '0;
        end else if (slot_end) begin
            presc_reg <= '0;
            idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // A LOAD on the frame cycle lands in pending while the older pending value moves to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_reg <= '0;
            pend_dp_reg   <= '0;
            pend_en_reg   <= '0;
            pending_reg   <= 1'b0;
            act_data_reg  <= '0;
            act_dp_reg    <= '0;
            act_en_reg    <= '0;
        end else begin
            if (frame && pending_reg) begin
                act_data_reg <= pend_data_reg;
                act_dp_reg   <= pend_dp_reg;
                act_en_reg   <= pend_en_reg;
            end
            if (load) begin
                pend_data_reg <= data;
                pend_dp_reg   <= dp;
                pend_en_reg   <= dig_en;
                pending_reg   <= 1'b1;
            end else if (frame) begin
                pending_reg   <= 1'b0;
            end
        end
    end

    // Walk from the top digit down; disabled digits do not stop zero-blanking below them.
    always_comb begin
        logic upper_clear;
        lz_blank    = '0;
        upper_clear = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_blank[i] = lzb && (act_data_reg[4*i +: 4] == 4'h0) && upper_clear;
            upper_clear = upper_clear && (!act_en_reg[i] || (act_data_reg[4*i +: 4] == 4'h0));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [6:0] glyph;
            assign glyph          = lz_blank[gi] ? 7'h7F : hex_to_seg(act_data_reg[4*gi +: 4]);
            assign digit_seg[gi]  = act_en_reg[gi] ? {~act_dp_reg[gi], glyph} : 8'hFF;
            assign an_sel[gi]     = (idx_reg != IW'(gi));
        end
    endgenerate

    always_comb begin
        seg_sel = 8'hFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == IW'(i)) begin
                seg_sel = digit_seg[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg  <= '1;
            seg_reg <= 8'hFF;
        end else if (blank_gap) begin
            an_reg  <= '1;
            seg_reg <= 8'hFF;
        end else begin
            an_reg  <= an_sel;
            seg_reg <= seg_sel;
        end
    end

endmodule
